// File: rtl/ps2_frame_receiver.sv
// PS/2 device-to-host frame receiver: synchronizes and deglitches kclk, deframes
// 11-bit frames and presents the last two scan-code bytes with valid/error pulses.
module ps2_frame_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kclk,
  input  logic        kdata,
  output logic [15:0] keycode,
  output logic        oflag,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [7:0]    RUN_MAX = 8'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Data bits plus parity must carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  logic          kclk_meta_r, kclk_sync_r, kdata_meta_r, kdata_sync_r;
  logic          filt_kclk_r, filt_prev_r;
  logic [7:0]    run_cnt_r;
  logic          fall_s;
  state_t        state_r, state_s;
  logic [7:0]    shift_r, shift_s;
  logic [2:0]    bit_cnt_r, bit_cnt_s;
  logic          par_r, par_s;
  logic [TW-1:0] tmo_cnt_r, tmo_s;
  logic          good_s, bad_s;
  logic [15:0]   keycode_r;
  logic          oflag_r, err_r;

  assign fall_s  = filt_prev_r & ~filt_kclk_r;
  assign keycode = keycode_r;
  assign oflag   = oflag_r;
  assign err     = err_r;

  // Two-flop synchronizers for both PS/2 pins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kclk_meta_r  <= 1'b1;
      kclk_sync_r  <= 1'b1;
      kdata_meta_r <= 1'b1;
      kdata_sync_r <= 1'b1;
    end else begin
      kclk_meta_r  <= kclk;
      kclk_sync_r  <= kclk_meta_r;
      kdata_meta_r <= kdata;
      kdata_sync_r <= kdata_meta_r;
    end
  end

  // Clock deglitcher: follow a new level only after FILTER_LEN steady cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_kclk_r <= 1'b1;
      filt_prev_r <= 1'b1;
      run_cnt_r   <= 8'd0;
    end else begin
      filt_prev_r <= filt_kclk_r;
      if (kclk_sync_r != filt_kclk_r) begin
        if (run_cnt_r == RUN_MAX) begin
          filt_kclk_r <= kclk_sync_r;
          run_cnt_r   <= 8'd0;
        end else begin
          run_cnt_r <= run_cnt_r + 8'd1;
        end
      end else begin
        run_cnt_r <= 8'd0;
      end
    end
  end

  // Frame FSM next-state and datapath.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    par_s     = par_r;
    tmo_s     = tmo_cnt_r;
    good_s    = 1'b0;
    bad_s     = 1'b0;
    if (state_r == ST_IDLE) begin
      tmo_s = {TW{1'b0}};
      if (fall_s) begin
        if (kdata_sync_r == 1'b0) begin
          state_s   = ST_DATA;
          bit_cnt_s = 3'd0;
        end else begin
          bad_s = 1'b1;
        end
      end else begin
        state_s = ST_IDLE;
      end
    end else if (fall_s) begin
      tmo_s = {TW{1'b0}};
      case (state_r)
        ST_DATA: begin
          shift_s   = {kdata_sync_r, shift_r[7:1]};
          bit_cnt_s = bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            state_s = ST_PARITY;
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_PARITY: begin
          par_s   = kdata_sync_r;
          state_s = ST_STOP;
        end
        ST_STOP: begin
          state_s = ST_IDLE;
          if (kdata_sync_r && odd_parity_ok(shift_r, par_r)) begin
            good_s = 1'b1;
          end else begin
            bad_s = 1'b1;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end else if (tmo_cnt_r == TMO_MAX) begin
      state_s = ST_IDLE;
      tmo_s   = {TW{1'b0}};
      bad_s   = 1'b1;
    end else begin
      tmo_s = tmo_cnt_r + TW'(1);
    end
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      shift_r   <= 8'h00;
      bit_cnt_r <= 3'd0;
      par_r     <= 1'b0;
      tmo_cnt_r <= {TW{1'b0}};
      keycode_r <= 16'h0000;
      oflag_r   <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      par_r     <= par_s;
      tmo_cnt_r <= tmo_s;
      oflag_r   <= good_s;
      err_r     <= bad_s;
      if (good_s) begin
        keycode_r <= {keycode_r[7:0], shift_r};
      end else begin
        keycode_r <= keycode_r;
      end
    end
  end

endmodule
